mux_arb_pipe: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered selector for operand/result steering in the TPU datapath.
//  Two selection modes: fixed (explicit select) and round-robin among requesting channels.

---
 rtl/mux_arb_pipe.sv | 120 ++++++++++++
 tb/tb_mux_arb_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_pipe.sv
// N-channel registered selector with fixed or round-robin channel choice.
// One output register stage with valid/ready back-pressure; data passes bit-exact.
module mux_arb_pipe #(
   parameter int WIDTH = 17,
   parameter int N     = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   input  logic                 out_ready
);

   localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

   logic [WIDTH-1:0] ch_data [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_chan_q,  out_chan_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   logic             load;
   logic             sel_ok;
   logic             rr_found;
   logic [SELW-1:0]  rr_idx;
   logic             gnt_any;
   logic [SELW-1:0]  gnt_idx;
   int               scan_k;
   int               nxt_k;

   // Grants are suppressed while stalled and during reset so no word is lost.
   assign load   = (!out_valid_q || out_ready) && !rst;
   assign sel_ok = ({1'b0, sel} < N_EXT);

   // Round-robin scan starting at ptr, wrapping modulo N.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      scan_k   = 0;
      for (int j = 0; j < N; j++) begin
         scan_k = int'(ptr_q) + j;
         if (scan_k >= N) scan_k = scan_k - N;
         if (!rr_found && in_valid[scan_k]) begin
            rr_found = 1'b1;
            rr_idx   = SELW'(scan_k);
         end
      end
   end

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (load) begin
         if (mode) begin
            gnt_any = rr_found;
            gnt_idx = rr_idx;
         end else if (sel_ok) begin
            gnt_any = in_valid[sel];
            gnt_idx = sel;
         end
      end
   end

   generate
      for (gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready[gi] = gnt_any && (gnt_idx == SELW'(gi));
      end
   endgenerate

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      nxt_k       = int'(gnt_idx) + 1;
      if (nxt_k >= N) nxt_k = 0;
      if (gnt_any) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[gnt_idx];
         out_chan_d  = gnt_idx;
         if (mode) ptr_d = SELW'(nxt_k);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Directed self-checking bench for mux_arb_pipe with hand-computed expectations.
module tb_mux_arb_pipe;

   localparam int WIDTH = 17;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N-1:0]         in_valid;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_chan;
   logic                 out_ready;

   int checks = 0;
   int errors = 0;

   localparam logic [WIDTH-1:0] CH0 = 17'h1FFFF;
   localparam logic [WIDTH-1:0] CH1 = 17'h00055;
   localparam logic [WIDTH-1:0] CH2 = 17'h1ABCD;
   localparam logic [WIDTH-1:0] CH3 = 17'h10001;

   logic [WIDTH-1:0] exp_data [N];

   mux_arb_pipe #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_data[0] = CH0;
      exp_data[1] = CH1;
      exp_data[2] = CH2;
      exp_data[3] = CH3;
      in_data   = {CH3, CH2, CH1, CH0};
      rst       = 1'b1;
      mode      = 1'b0;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      step();
      step();
      $display("txn reset: out_valid=%0b out_data=%0h out_chan=%0d", out_valid, out_data, out_chan);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_chan", 32'(out_chan), 32'h0);

      // Fixed select of channel 2
      rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      chk("fix_in_ready", 32'(in_ready), 32'h4);
      step();
      $display("txn fixed sel=2: out_valid=%0b out_data=%0h out_chan=%0d", out_valid, out_data, out_chan);
      chk("fix_out_valid", 32'(out_valid), 32'h1);
      chk("fix_out_data", 32'(out_data), 32'(CH2));
      chk("fix_out_chan", 32'(out_chan), 32'h2);

      // Fixed select of an idle channel: no grant, output drains
      sel = 2'd1; in_valid = 4'b1101;
      #1;
      chk("fix_idle_in_ready", 32'(in_ready), 32'h0);
      step();
      $display("txn fixed idle: out_valid=%0b", out_valid);
      chk("fix_idle_drain", 32'(out_valid), 32'h0);

      // Round-robin with all channels requesting, from reset
      rst = 1'b1; step(); rst = 1'b0;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      chk("rr_all_first_ready", 32'(in_ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         step();
         $display("txn rr_all %0d: out_valid=%0b out_chan=%0d out_data=%0h", i, out_valid, out_chan, out_data);
         chk("rr_all_valid", 32'(out_valid), 32'h1);
         chk("rr_all_chan", 32'(out_chan), 32'(i % 4));
         chk("rr_all_data", 32'(out_data), 32'(exp_data[i % 4]));
      end

      // Round-robin sparse requests 1 and 3
      rst = 1'b1; step(); rst = 1'b0;
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_sparse_ready", 32'(in_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
         step();
         $display("txn rr_sparse %0d: out_chan=%0d out_data=%0h", i, out_chan, out_data);
         chk("rr_sparse_chan", 32'(out_chan), (i % 2 == 0) ? 32'h1 : 32'h3);
      end

      // Back-pressure holding a ch1 word
      rst = 1'b1; step(); rst = 1'b0;
      in_valid = 4'b0010; out_ready = 1'b0;
      step();
      chk("bp_load_data", 32'(out_data), 32'(CH1));
      in_valid = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         step();
         $display("txn stall %0d: out_valid=%0b out_data=%0h out_chan=%0d", i, out_valid, out_data, out_chan);
         chk("bp_hold_valid", 32'(out_valid), 32'h1);
         chk("bp_hold_data", 32'(out_data), 32'(CH1));
         chk("bp_hold_chan", 32'(out_chan), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'h4);
      step();
      $display("txn release: out_chan=%0d out_data=%0h", out_chan, out_data);
      chk("bp_release_chan", 32'(out_chan), 32'h2);
      chk("bp_release_data", 32'(out_data), 32'(CH2));

      // Drain and reload in the same cycle
      in_valid = 4'b1000;
      #1;
      chk("dl_in_ready", 32'(in_ready), 32'h8);
      step();
      $display("txn drain+load: out_valid=%0b out_data=%0h out_chan=%0d", out_valid, out_data, out_chan);
      chk("dl_valid", 32'(out_valid), 32'h1);
      chk("dl_data", 32'(out_data), 32'(CH3));
      chk("dl_chan", 32'(out_chan), 32'h3);

      // Reset mid-operation with a held word and ptr=3
      in_valid = 4'b0100;
      step();
      chk("mr_pre_chan", 32'(out_chan), 32'h2);
      out_ready = 1'b0; rst = 1'b1; in_valid = 4'b1111;
      #1;
      chk("mr_rst_in_ready", 32'(in_ready), 32'h0);
      step();
      $display("txn mid reset: out_valid=%0b out_data=%0h out_chan=%0d", out_valid, out_data, out_chan);
      chk("mr_valid", 32'(out_valid), 32'h0);
      chk("mr_data", 32'(out_data), 32'h0);
      chk("mr_chan", 32'(out_chan), 32'h0);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("mr_first_ready", 32'(in_ready), 32'h1);
      step();
      $display("txn post reset: out_chan=%0d out_data=%0h", out_chan, out_data);
      chk("mr_first_chan", 32'(out_chan), 32'h0);
      chk("mr_first_data", 32'(out_data), 32'(CH0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
